// File: rtl/ps2_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_scan_decoder_if
//
// Bundles the byte-in and event-out signals of ps2_scan_decoder.
//
// Parameters:
//   FIFO_DEPTH  event FIFO entries; sets the width of ev_count.
//
// Signals:
//   byte_valid  one-cycle strobe, byte_data valid this cycle
//   byte_data   received scan-code byte
//   ev_pop      consume the head event (ignored when ev_valid=0)
//   ev_valid    FIFO non-empty
//   ev_code     head event key code (0 when empty)
//   ev_ext      head event was E0-prefixed (0 when empty)
//   ev_brk      head event is a release (0 when empty)
//   ev_count    entries held
//   overflow    sticky event-dropped flag
//
// Modports:
//   master  the side that feeds bytes and pops events (receiver/consumer)
//   slave   the decoder itself
// ---------------------------------------------------------------------------
interface ps2_scan_decoder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          ev_pop;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_brk;
  logic [CW-1:0] ev_count;
  logic          overflow;

  modport master (
    output byte_valid, byte_data, ev_pop,
    input  ev_valid, ev_code, ev_ext, ev_brk, ev_count, overflow
  );

  modport slave (
    input  byte_valid, byte_data, ev_pop,
    output ev_valid, ev_code, ev_ext, ev_brk, ev_count, overflow
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scan_decoder
//
// Turns the PS/2 Set-2 byte stream (one strobe per received byte) into key
// events {code, extended, break}. E0 marks an extended key, F0 a release.
// Decoded events are queued in a small circular FIFO that the display /
// control logic pops.
//
// Parameters:
//   FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  cycles a partial prefix sequence may wait for its next byte
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ps2_scan_decoder_if.slave (byte input, event FIFO output)
//
// Optional build macro:
//   REPEAT_FILTER_EN  when defined, typematic repeats of the currently held
//                     key are suppressed via a held-key register. When not
//                     defined, every decoded event is pushed.
// ---------------------------------------------------------------------------
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               rst_n,
  ps2_scan_decoder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  // Bytes that carry no key information (keyboard replies, BAT, pause
  // prefix, errors): consumed without touching decoder state.
  localparam int N_DISC = 9;
  localparam logic [7:0] DISCARD [N_DISC] = '{
    8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    BRK  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Decoder state
  // -------------------------------------------------------------------------
  state_t        state_reg;
  state_t        state_next;
  logic          ext_r;
  logic          ext_next;
  logic [TW-1:0] tmo_cnt;

  // Discard-set match
  logic [N_DISC-1:0] disc_hit;
  logic              is_discard;

  for (genvar gi = 0; gi < N_DISC; gi++) begin : g_disc
    assign disc_hit[gi] = (bus.byte_data == DISCARD[gi]);
  end

  assign is_discard = |disc_hit;

  // The timer expires on the edge where it would reach TIMEOUT_CYC. On that
  // edge the sequence is abandoned and any byte arriving alongside it is
  // decoded as if the FSM were already back in IDLE.
  logic   tmo_fire;
  state_t cur_state;
  logic   cur_ext;

  assign tmo_fire  = (state_reg != IDLE) && (tmo_cnt == TMO_LAST);
  assign cur_state = tmo_fire ? IDLE : state_reg;
  assign cur_ext   = tmo_fire ? 1'b0 : ext_r;

  // Decoded event for this cycle (before any repeat filtering)
  logic       dec_push;
  logic       dec_ext;
  logic       dec_brk;
  logic [9:0] dec_ev;

  always_comb begin
    state_next = cur_state;
    ext_next   = cur_ext;
    dec_push   = 1'b0;
    dec_ext    = 1'b0;
    dec_brk    = 1'b0;
    if (bus.byte_valid && !is_discard) begin
      case (cur_state)
        IDLE: begin
          if (bus.byte_data == CODE_E0) begin
            state_next = EXT;
          end else if (bus.byte_data == CODE_F0) begin
            state_next = BRK;
            ext_next   = 1'b0;
          end else begin
            dec_push = 1'b1;
          end
        end
        EXT: begin
          if (bus.byte_data == CODE_E0) begin
            state_next = EXT;
          end else if (bus.byte_data == CODE_F0) begin
            state_next = BRK;
            ext_next   = 1'b1;
          end else begin
            dec_push   = 1'b1;
            dec_ext    = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          // A second prefix after F0 is a protocol error: drop the sequence.
          if (bus.byte_data == CODE_E0 || bus.byte_data == CODE_F0) begin
            state_next = IDLE;
            ext_next   = 1'b0;
          end else begin
            dec_push   = 1'b1;
            dec_ext    = cur_ext;
            dec_brk    = 1'b1;
            state_next = IDLE;
            ext_next   = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          ext_next   = 1'b0;
        end
      endcase
    end
  end

  assign dec_ev = {bus.byte_data, dec_ext, dec_brk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ext_r     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state_reg <= state_next;
      ext_r     <= ext_next;
      // Any byte (even a discarded one) restarts the wait for the next byte.
      if (bus.byte_valid || state_next == IDLE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional typematic repeat filter
  // -------------------------------------------------------------------------
  logic push_req;

`ifdef REPEAT_FILTER_EN
  logic       held_v;
  logic       held_ext;
  logic [7:0] held_code;
  logic       held_match;

  assign held_match = held_v && (held_ext == dec_ext) && (held_code == bus.byte_data);

  // Repeated makes of the held key are swallowed here, before the FIFO, so
  // they can never count as an overflow.
  assign push_req = dec_push && !(held_match && !dec_brk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_v    <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= 8'h00;
    end else if (dec_push) begin
      if (!dec_brk) begin
        if (!held_match) begin
          held_v    <= 1'b1;
          held_ext  <= dec_ext;
          held_code <= bus.byte_data;
        end
      end else if (held_match) begin
        held_v <= 1'b0;
      end
    end
  end
`else
  assign push_req = dec_push;
`endif

  // -------------------------------------------------------------------------
  // Event FIFO
  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate counter.
  logic [AW:0] wptr_reg;
  logic [AW:0] rptr_reg;
  logic [9:0]  mem [FIFO_DEPTH];
  logic        empty;
  logic        full;
  logic        pop_eff;
  logic        do_push;
  logic        overflow_reg;
  logic [9:0]  head;

  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign pop_eff = bus.ev_pop && !empty;
  // A same-cycle pop frees the slot the push needs, even when full.
  assign do_push = push_req && (!full || pop_eff);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_reg[AW-1:0]] <= dec_ev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop_eff) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      if (push_req && full && !pop_eff) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Head outputs read the storage directly; storage is not reset, so the
  // fields are forced to zero whenever the FIFO is empty.
  assign head         = mem[rptr_reg[AW-1:0]];
  assign bus.ev_valid = !empty;
  assign bus.ev_code  = empty ? 8'h00 : head[9:2];
  assign bus.ev_ext   = empty ? 1'b0  : head[1];
  assign bus.ev_brk   = empty ? 1'b0  : head[0];
  assign bus.ev_count = wptr_reg - rptr_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumes the byte stream of the PS/2 keyboard receiver (one strobe per received scan-code byte) and turns Set-2 prefix sequences (E0, F0) into single key events {code, extended, break}. Events are buffered in a small FIFO popped by the display/control logic. Sits directly downstream of the PS/2 receiver, upstream of the seven-segment display path.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYC, 50000: clk cycles a partial prefix sequence may wait for its next byte before being abandoned.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- byte_valid  in  1  one-cycle strobe; byte_data valid this cycle.
- byte_data  in  8  received scan-code byte.
- ev_pop  in  1  consume head event; ignored when ev_valid=0.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  8  head event key code; 0 when empty.
- ev_ext  out  1  head event was E0-prefixed; 0 when empty.
- ev_brk  out  1  head event is a release (F0); 0 when empty.
- ev_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky: an event was dropped on a full FIFO; cleared only by reset.

## Operation
- FSM states IDLE, EXT, BRK; registers ext_r (1 bit), tmo_cnt (wide enough for TIMEOUT_CYC).
- Discard set D = {00, AA, E1, EE, FA, FC, FD, FE, FF}: byte consumed, state and ext_r unchanged, no event.
- IDLE: E0 → EXT; F0 → BRK with ext_r=0; other non-D byte → push {byte,0,0}.
- EXT: E0 → stay EXT; F0 → BRK with ext_r=1; other non-D byte → push {byte,1,0}, → IDLE.
- BRK: E0 or F0 → protocol error, → IDLE, ext_r=0, no event; other non-D byte → push {byte,ext_r,1}, → IDLE, ext_r=0.
- Timeout: tmo_cnt clears on every byte_valid and in IDLE; increments each cycle in EXT/BRK; on reaching TIMEOUT_CYC → IDLE, ext_r=0, nothing pushed.
- FIFO: circular buffer, write/read pointers one bit wider than address; full when pointers differ only in MSB.
- Push when full without same-cycle pop: event dropped, overflow←1. Push and pop in same cycle when full: both succeed, count unchanged. Push and pop when empty: push only (pop ignored).
- Pointer wrap at FIFO_DEPTH is seamless; no entry lost or duplicated.

## Timing
- Reset: state IDLE, ext_r=0, tmo_cnt=0, pointers 0; ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, ev_count=0, overflow=0.
- Reset asserted mid-sequence or with FIFO occupied: all contents and partial prefix discarded immediately.
- One byte accepted per cycle; back-to-back byte_valid supported.
- Latency: byte_valid at edge N completing an event → entry visible (ev_valid, ev_count updated) after edge N; head outputs combinational from FIFO storage at read pointer.
- ev_pop at edge N: next entry (or empty) visible after edge N.
- Timeout fires exactly TIMEOUT_CYC cycles after the last prefix byte; a byte arriving in that same cycle is processed as in IDLE.

## Configuration
- REPEAT_FILTER_EN defined: held-key register {held_v, held_ext, held_code}, reset 0. Make event equal to held key → not pushed (typematic suppressed). Other make → pushed, held updated. Break equal to held key → pushed, held_v←0. Other break → pushed, held unchanged. Filtered makes never set overflow.
- Not defined: every decoded event pushed; no held-key register.

## Test plan
- Bytes 1C; pop → ev_valid 1 cycle after strobe, {1C,0,0}; after pop ev_valid=0, ev_count=0.
- Bytes E0 F0 74 → single event {74,1,1}; E0 75 → {75,1,0}; F0 E0 then 1C → only {1C,0,0}.
- FIFO_DEPTH=4, bytes 15 16 1D 24 2D, no pop → ev_count=4, overflow=1, head 15; pop+push 35 same cycle when full → count 4, tail 35.
- TIMEOUT_CYC=20: E0, wait 20 cycles, 1C → {1C,0,0}; E0, wait 19 cycles, 1C → {1C,1,0}; AA/FA interleaved produce no events.
- REPEAT_FILTER_EN: 1C 1C 1C F0 1C 1C → {1C,0,0},{1C,0,1},{1C,0,0}; without macro → six-byte stream yields 5 events.
- Reset pulsed after E0 F0 with 2 events queued → all outputs 0; then 1C → {1C,0,0}.
